// File: rtl/mod_updown_counter_pkg.sv
// Shared constants for the up/down modulo counter and its BCD presentation.
package mod_updown_counter_pkg;

  localparam int unsigned DEFAULT_MODULUS = 100;
  localparam int unsigned DEFAULT_DIGITS  = 2;
  localparam int unsigned BCD_DIGIT_W     = 4;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_LOAD,
    SEL_STEP
  } count_sel_e;

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational binary-to-BCD conversion using the shift-and-add-3 (double-dabble) method.
module bin_to_bcd
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
  input  logic [WIDTH-1:0]              bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;

  logic [BCD_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (acc[BCD_DIGIT_W*d +: BCD_DIGIT_W] >= 4'd5)
          acc[BCD_DIGIT_W*d +: BCD_DIGIT_W] = acc[BCD_DIGIT_W*d +: BCD_DIGIT_W] + 4'd3;
      end
      acc = {acc[BCD_W-2:0], bin[WIDTH-1-i]};
    end
    bcd = acc;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with wrap/saturate boundary modes, load, terminal-count pulse and BCD view.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned MODULUS = DEFAULT_MODULUS,
  parameter int unsigned DIGITS  = DEFAULT_DIGITS,
  parameter int unsigned WIDTH   = $clog2(MODULUS)
) (
  input  logic                          in_clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up,
  input  logic                          sat,
  input  logic                          load,
  input  logic [WIDTH-1:0]              load_val,
  output logic [WIDTH-1:0]              q,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  count_sel_e                      sel;
  logic [WIDTH-1:0]                count;
  logic [WIDTH-1:0]                next_count;
  logic                            next_tc;
  logic [BCD_DIGIT_W*DIGITS-1:0]   next_bcd;

  always_comb begin
    sel        = SEL_HOLD;
    next_count = count;
    next_tc    = 1'b0;
    if (load)
      sel = SEL_LOAD;
    else if (en)
      sel = SEL_STEP;

    unique case (sel)
      SEL_LOAD: next_count = (load_val > MAX) ? MAX : load_val;
      SEL_STEP: begin
        if (up) begin
          if (count == MAX) begin
            next_count = sat ? MAX : '0;
            next_tc    = 1'b1;
          end else begin
            next_count = count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            next_count = sat ? '0 : MAX;
            next_tc    = 1'b1;
          end else begin
            next_count = count - WIDTH'(1);
          end
        end
      end
      default: next_count = count;
    endcase
  end

  // BCD is converted from the next count so the registered digits land on the same edge as q.
  bin_to_bcd #(
    .WIDTH (WIDTH),
    .DIGITS(DIGITS)
  ) u_bin_to_bcd (
    .bin(next_count),
    .bcd(next_bcd)
  );

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      bcd   <= '0;
      tc    <= 1'b0;
    end else begin
      count <= next_count;
      bcd   <= next_bcd;
      tc    <= next_tc;
    end
  end

  assign q = count;

endmodule
